datapath_bus: RTL
=================

# datapath_bus

Processor datapath that executes the control-unit strobes. It holds the eight general registers R0..R7, the instruction register IR, the ALU operand register A, the ALU result register G, and a Z/C flag register. It also contains the shared bus multiplexer and the add/subtract ALU. The block sits directly downstream of the control unit: it consumes IRin/Rin/Rout/Ain/Gin/Gout/AddSub/DINout and returns IR, whose opcode and fields drive the control unit's decode.

## Interface
- N, default 9, data/bus width; must be ≥ 9.
- Clock  in  1  rising-edge clock, single clock domain.
- Resetn  in  1  asynchronous, active-low reset.
- DIN  in  N  external data / instruction word.
- IRin  in  1  load IR from DIN[8:0].
- Rin  in  8  one-hot write enables for R0..R7.
- Rout  in  8  one-hot bus-drive enables for R0..R7.
- Ain  in  1  load A from bus.
- Gin  in  1  load G and flags from ALU result.
- Gout  in  1  G drives bus.
- AddSub  in  1  0 = A+bus, 1 = A−bus.
- DINout  in  1  DIN drives bus.
- Dbg_sel  in  3  register index for debug read.
- IR  out  9  instruction register.
- BusWires  out  N  current bus value (combinational).
- Dbg_data  out  N  R[Dbg_sel] (combinational).
- Z  out  1  zero flag.
- C  out  1  carry on add, borrow on sub.
- BusConflict  out  1  sticky: more than one bus source was asserted.

## Operation
- Bus source priority: DINout > Gout > Rout[0] > … > Rout[7]. With no source asserted, the bus is 0.
- ALU: result = A + bus, or A − bus, in N+1 bits, computed combinationally.
  - G gets result[N−1:0].
  - Z = (result[N−1:0] == 0).
  - C = result[N] on add.
  - C = 1 iff A < bus (unsigned) on sub.
- Z and C load only when Gin is asserted.
- Loads on a rising edge:
  - R[i] ← bus when Rin[i].
  - A ← bus when Ain.
  - G, Z, C ← ALU when Gin.
  - IR ← DIN[8:0] when IRin. IR never loads from the bus.
- Rin, Ain, Gin and IRin may be asserted together; every destination captures the same bus value in that cycle.
- Simultaneous cases:
  - Ain with Gin: the ALU uses the old A.
  - Rin[i] with Rout[i]: R[i] reloads its own value.
  - Gout with Gin: the ALU uses the old G on the bus.
- BusConflict is set on the rising edge following any cycle in which more than one of {DINout, Gout, Rout[7:0]} is 1. It stays set until reset. The bus still follows the priority order during the conflicting cycle.
- Non-one-hot Rin is legal: all selected registers load.

## Timing
- Reset: asserting Resetn low immediately clears R0..R7, A, G, IR, Z, C and BusConflict to 0. This holds mid-instruction, regardless of Clock. The first load takes effect on the first rising edge after Resetn rises.
- BusWires and Dbg_data are combinational, with no register stage.
- All register updates have 1-cycle latency.
- add/sub instruction timing:
  - T1: Rout[x] + Ain.
  - T2: Rout[y] + Gin.
  - T3: Gout + Rin[x].
  - Rx holds the result after the T3 edge.
- mv and mvi complete in the T1 edge.
- IR is valid from the T0 edge onward.

## Structure
- Shared package cpu_pkg:
  - opcode constants OP_MV = 3'b000, OP_MVI = 3'b001, OP_ADD = 3'b010, OP_SUB = 3'b011.
  - IR field positions: opcode [2:0], Rx [5:3], Ry [8:6].
  - default width DATA_W = 9.
- One sub-module, regn: N-bit register with load enable and asynchronous active-low clear. It is instantiated for R0..R7, A, G and IR.
- Bus mux, ALU and conflict detect are inline in datapath_bus.

## Test plan
- Reset: load registers, then pull Resetn low between edges → IR, all R, A, G, Z, C and BusConflict read 0 before the next edge.
- mvi: DIN=9'h005, DINout=1, Rin=8'b0000_0001 for one edge → Dbg_data(sel 0)=5. Then Rout=8'b0000_0001, Rin=8'b0000_0100 → R2=5.
- add: R0=5, R1=3; run the T1/T2/T3 sequence → R0=8, Z=0, C=0. Repeat with R0=9'h1FF, R1=1 → R0=0, Z=1, C=1.
- sub: R0=3, R1=5 → R0=9'h1FE, C=1, Z=0. Repeat with R0=5, R1=5 → R0=0, Z=1, C=0.
- Conflict: DINout=1, Gout=1, Rin[3]=1, DIN=7 → R3=7 and BusConflict=1 after the edge. BusConflict stays 1 through later clean cycles and clears only on Resetn.
- Simultaneous: Ain and Gin in the same cycle with A=2 and bus=4 → G=6 (old A), A=4 afterwards.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, IR field and width definitions for the cpu slice
package cpu_pkg;

  localparam int DATA_W = 9;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_MV  = 3'b000;
  localparam opcode_t OP_MVI = 3'b001;
  localparam opcode_t OP_ADD = 3'b010;
  localparam opcode_t OP_SUB = 3'b011;

  localparam int IR_OP_LSB = 0;
  localparam int IR_RX_LSB = 3;
  localparam int IR_RY_LSB = 6;

  function automatic opcode_t ir_opcode(input logic [8:0] ir);
    return ir[IR_OP_LSB +: 3];
  endfunction

  function automatic logic [2:0] ir_rx(input logic [8:0] ir);
    return ir[IR_RX_LSB +: 3];
  endfunction

  function automatic logic [2:0] ir_ry(input logic [8:0] ir);
    return ir[IR_RY_LSB +: 3];
  endfunction

endpackage

// File: rtl/regn.sv
// rtl/regn.sv - W-bit register with load enable and asynchronous active-low clear
module regn #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/datapath_bus.sv
// rtl/datapath_bus.sv - register file, shared bus mux and add/sub ALU driven by control strobes
module datapath_bus
  import cpu_pkg::*;
#(
  parameter int N = DATA_W
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic [N-1:0] DIN,
  input  logic         IRin,
  input  logic [7:0]   Rin,
  input  logic [7:0]   Rout,
  input  logic         Ain,
  input  logic         Gin,
  input  logic         Gout,
  input  logic         AddSub,
  input  logic         DINout,
  input  logic [2:0]   Dbg_sel,
  output logic [8:0]   IR,
  output logic [N-1:0] BusWires,
  output logic [N-1:0] Dbg_data,
  output logic         Z,
  output logic         C,
  output logic         BusConflict
);

  logic [N-1:0] r_q [8];
  logic [N-1:0] a_q;
  logic [N-1:0] g_q;
  logic [N:0]   alu_res;
  logic [9:0]   srcs;
  logic         multi_src;

  for (genvar i = 0; i < 8; i++) begin : g_regs
    regn #(.W(N)) u_r (
      .clk   (Clock),
      .rst_n (Resetn),
      .ld    (Rin[i]),
      .d     (BusWires),
      .q     (r_q[i])
    );
  end

  regn #(.W(N)) u_a (
    .clk   (Clock),
    .rst_n (Resetn),
    .ld    (Ain),
    .d     (BusWires),
    .q     (a_q)
  );

  regn #(.W(N)) u_g (
    .clk   (Clock),
    .rst_n (Resetn),
    .ld    (Gin),
    .d     (alu_res[N-1:0]),
    .q     (g_q)
  );

  // IR is fed straight from DIN so an instruction fetch never depends on bus state
  regn #(.W(9)) u_ir (
    .clk   (Clock),
    .rst_n (Resetn),
    .ld    (IRin),
    .d     (DIN[8:0]),
    .q     (IR)
  );

  // Walk R7 down to R0 so the lowest-numbered asserted Rout wins
  always_comb begin
    BusWires = '0;
    if (DINout) begin
      BusWires = DIN;
    end else if (Gout) begin
      BusWires = g_q;
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (Rout[i]) BusWires = r_q[i];
      end
    end
  end

  // Bit N is the carry on add and, with a zero-extended subtract, the borrow (A < bus)
  always_comb begin
    if (AddSub) alu_res = {1'b0, a_q} - {1'b0, BusWires};
    else        alu_res = {1'b0, a_q} + {1'b0, BusWires};
  end

  assign Dbg_data  = r_q[Dbg_sel];
  assign srcs      = {DINout, Gout, Rout};
  assign multi_src = |(srcs & (srcs - 10'd1));

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      Z           <= 1'b0;
      C           <= 1'b0;
      BusConflict <= 1'b0;
    end else begin
      if (Gin) begin
        Z <= (alu_res[N-1:0] == '0);
        C <= alu_res[N];
      end
      if (multi_src) BusConflict <= 1'b1;
    end
  end

endmodule
